// File: rtl/echo_indication_arbiter_pkg.sv
// Shared types and helpers for the EchoIndication arbiter slice.
package echo_arb_pkg;

    typedef enum logic {
        MSG_HEARD  = 1'b0,
        MSG_HEARD2 = 1'b1
    } msg_kind_t;

    localparam int unsigned PAYLOAD_W = 32;

    typedef struct packed {
        msg_kind_t            kind;
        logic [PAYLOAD_W-1:0] data;
    } echo_msg_t;

    function automatic logic [PAYLOAD_W-1:0] pack_heard2(input logic [15:0] a, input logic [15:0] b);
        return {a, b};
    endfunction

    function automatic logic [15:0] heard2_a(input logic [PAYLOAD_W-1:0] d);
        return d[31:16];
    endfunction

    function automatic logic [15:0] heard2_b(input logic [PAYLOAD_W-1:0] d);
        return d[15:0];
    endfunction

endpackage

// File: rtl/echo_indication_arbiter_if.sv
// Requester-side and indication-side signals of the echo indication arbiter.
interface echo_indication_arbiter_if
    import echo_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) ();
    logic [NREQ-1:0]           req_ENA;
    logic [NREQ-1:0]           req_RDY;
    logic [NREQ-1:0]           req_type;
    logic [PAYLOAD_W*NREQ-1:0] req_data;
    logic                      heard__ENA;
    logic                      heard__RDY;
    logic [31:0]               heard__v;
    logic                      heard2__ENA;
    logic                      heard2__RDY;
    logic [15:0]               heard2__a;
    logic [15:0]               heard2__b;
    logic [IDW-1:0]            grant_id;
    logic                      stall_clr;
    logic [15:0]               stall_cnt;

    // Arbiter side
    modport slave (
        input  req_ENA, req_type, req_data, heard__RDY, heard2__RDY, stall_clr,
        output req_RDY, heard__ENA, heard__v, heard2__ENA, heard2__a, heard2__b,
               grant_id, stall_cnt
    );

    // Environment side (requesters + host indication port)
    modport master (
        output req_ENA, req_type, req_data, heard__RDY, heard2__RDY, stall_clr,
        input  req_RDY, heard__ENA, heard__v, heard2__ENA, heard2__a, heard2__b,
               grant_id, stall_cnt
    );

endinterface

// File: rtl/echo_indication_arbiter_rr_pick.sv
// Combinational round-robin picker: first set elig bit scanning from ptr upward, wrapping.
module echo_rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] elig,
    input  logic [IDW-1:0]  ptr,
    output logic            found,
    output logic [IDW-1:0]  winner
);

    // Scan ptr, ptr+1, ... mod NREQ and keep the first eligible index
    always_comb begin
        int unsigned idx;
        idx    = 0;
        found  = 1'b0;
        winner = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && elig[idx]) begin
                found  = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/echo_indication_arbiter.sv
// Shares one EchoIndication channel (heard / heard2) between NREQ echo engines,
// each with a one-entry holding buffer, issuing one message per cycle round-robin.
module echo_indication_arbiter
    import echo_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                    CLK,
    input  logic                    nRST,
    echo_indication_arbiter_if.slave bus
);

    logic [NREQ-1:0] valid;
    echo_msg_t       msg_q [NREQ];
    logic [IDW-1:0]  ptr;
    logic [15:0]     stall_q;

    logic [NREQ-1:0] elig;
    logic            found;
    logic            issue;
    logic [IDW-1:0]  winner;
    echo_msg_t       win_msg;
    logic            hena;
    logic            h2ena;

    // An entry is eligible when buffered and its own indication method is ready
    always_comb begin
        elig = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            elig[i] = valid[i] &&
                      ((msg_q[i].kind == MSG_HEARD2) ? bus.heard2__RDY : bus.heard__RDY);
        end
    end

    echo_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .elig   (elig),
        .ptr    (ptr),
        .found  (found),
        .winner (winner)
    );

    // Drive the indication port from the winning buffer; nothing is issued while in reset
    always_comb begin
        issue       = found && nRST;
        win_msg     = msg_q[winner];
        hena        = issue && (win_msg.kind == MSG_HEARD);
        h2ena       = issue && (win_msg.kind == MSG_HEARD2);
        bus.heard__ENA  = hena;
        bus.heard2__ENA = h2ena;
        bus.heard__v    = hena  ? win_msg.data : '0;
        bus.heard2__a   = h2ena ? heard2_a(win_msg.data) : '0;
        bus.heard2__b   = h2ena ? heard2_b(win_msg.data) : '0;
        bus.grant_id    = issue ? winner : '0;
        bus.req_RDY     = ~valid;
        bus.stall_cnt   = stall_q;
    end

    // Holding buffers: fill when empty, drain on issue (never both in one cycle)
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            valid <= '0;
            for (int unsigned i = 0; i < NREQ; i++) begin
                msg_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (issue && (winner == IDW'(i))) begin
                    valid[i] <= 1'b0;
                end else if (bus.req_ENA[i] && !valid[i]) begin
                    valid[i]      <= 1'b1;
                    msg_q[i].kind <= msg_kind_t'(bus.req_type[i]);
                    msg_q[i].data <= bus.req_data[PAYLOAD_W*i +: PAYLOAD_W];
                end
            end
        end
    end

    // Round-robin pointer moves just past the last winner
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            ptr <= '0;
        end else if (issue) begin
            ptr <= (int'(winner) == NREQ - 1) ? '0 : winner + IDW'(1);
        end
    end

    // Saturating count of cycles with something buffered but nothing issued
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            stall_q <= '0;
        end else if (bus.stall_clr) begin
            stall_q <= '0;
        end else if ((|valid) && !issue && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_echo_indication_arbiter.sv
// Self-checking bench for echo_indication_arbiter: directed scenarios plus a
// randomized run against a behavioural model of the buffers and rotation.
module tb_echo_indication_arbiter;
    import echo_arb_pkg::*;

    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    int   checks = 0;
    int   errors = 0;

    echo_indication_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    echo_indication_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    // Behavioural model: per-requester slot, rotation start, blocked-cycle count
    bit          m_valid [NREQ];
    bit          m_kind  [NREQ];
    logic [31:0] m_data  [NREQ];
    int          m_ptr   = 0;
    int          m_stall = 0;

    function automatic int m_win();
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NREQ;
            if (m_valid[idx] && (m_kind[idx] ? bus.heard2__RDY : bus.heard__RDY))
                return idx;
        end
        return -1;
    endfunction

    always @(posedge CLK) begin
        int w;
        bit anyv;
        if (!nRST) begin
            for (int i = 0; i < NREQ; i++) begin
                m_valid[i] = 0; m_kind[i] = 0; m_data[i] = '0;
            end
            m_ptr   = 0;
            m_stall = 0;
        end else begin
            w    = m_win();
            anyv = 0;
            for (int i = 0; i < NREQ; i++) anyv |= m_valid[i];
            for (int i = 0; i < NREQ; i++) begin
                if (w == i) m_valid[i] = 0;
                else if (bus.req_ENA[i] && !m_valid[i]) begin
                    m_valid[i] = 1;
                    m_kind[i]  = bus.req_type[i];
                    m_data[i]  = bus.req_data[32*i +: 32];
                end
            end
            if (w >= 0) m_ptr = (w + 1) % NREQ;
            if (bus.stall_clr) m_stall = 0;
            else if (anyv && w < 0 && m_stall < 65535) m_stall++;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_ENA     = '0;
        bus.req_type    = '0;
        bus.req_data    = '0;
        bus.heard__RDY  = 1'b0;
        bus.heard2__RDY = 1'b0;
        bus.stall_clr   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.req_RDY !== 4'hF) begin errors++; $display("FAIL reset_rdy: got %h want f", bus.req_RDY); end
        checks++; if (bus.heard__ENA !== 1'b0 || bus.heard2__ENA !== 1'b0) begin errors++; $display("FAIL reset_ena: got %b%b want 00", bus.heard__ENA, bus.heard2__ENA); end
        checks++; if (bus.grant_id !== 2'd0) begin errors++; $display("FAIL reset_gid: got %0d want 0", bus.grant_id); end
        checks++; if (bus.stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall: got %h want 0", bus.stall_cnt); end
        checks++; if (bus.heard__v !== 32'd0 || bus.heard2__a !== 16'd0 || bus.heard2__b !== 16'd0) begin errors++; $display("FAIL reset_payload: got %h %h %h want 0", bus.heard__v, bus.heard2__a, bus.heard2__b); end
    endtask

    task automatic test_single_heard();
        bus.heard__RDY  = 1'b1;
        bus.heard2__RDY = 1'b1;
        bus.req_ENA     = 4'b0001;
        bus.req_type    = 4'b0000;
        bus.req_data    = '0;
        bus.req_data[31:0] = 32'hDEADBEEF;
        tick();
        bus.req_ENA = '0;
        checks++; if (bus.heard__ENA !== 1'b1 || bus.heard2__ENA !== 1'b0) begin errors++; $display("FAIL single_ena: got %b%b want 10", bus.heard__ENA, bus.heard2__ENA); end
        checks++; if (bus.heard__v !== 32'hDEADBEEF) begin errors++; $display("FAIL single_v: got %h want deadbeef", bus.heard__v); end
        checks++; if (bus.grant_id !== 2'd0) begin errors++; $display("FAIL single_gid: got %0d want 0", bus.grant_id); end
        checks++; if (bus.req_RDY !== 4'b1110) begin errors++; $display("FAIL single_rdy_low: got %b want 1110", bus.req_RDY); end
        tick();
        checks++; if (bus.req_RDY !== 4'hF || bus.heard__ENA !== 1'b0) begin errors++; $display("FAIL single_after: got rdy=%b ena=%b want 1111/0", bus.req_RDY, bus.heard__ENA); end
    endtask

    task automatic test_all_heard2();
        logic [31:0] d;
        do_reset();
        bus.heard__RDY  = 1'b1;
        bus.heard2__RDY = 1'b1;
        bus.req_ENA     = 4'hF;
        bus.req_type    = 4'hF;
        for (int i = 0; i < NREQ; i++) begin
            d = 32'h0001_0002 * (i + 1);
            bus.req_data[32*i +: 32] = d;
        end
        tick();
        bus.req_ENA = '0;
        for (int c = 0; c < NREQ; c++) begin
            checks++; if (bus.heard2__ENA !== 1'b1 || bus.heard__ENA !== 1'b0) begin errors++; $display("FAIL all_ena[%0d]: got %b%b want 01", c, bus.heard__ENA, bus.heard2__ENA); end
            checks++; if (bus.grant_id !== IDW'(c)) begin errors++; $display("FAIL all_gid[%0d]: got %0d want %0d", c, bus.grant_id, c); end
            checks++; if (bus.heard2__a !== 16'(c + 1) || bus.heard2__b !== 16'(2 * (c + 1))) begin errors++; $display("FAIL all_ab[%0d]: got %0d,%0d want %0d,%0d", c, bus.heard2__a, bus.heard2__b, c + 1, 2 * (c + 1)); end
            tick();
        end
        checks++; if (bus.heard2__ENA !== 1'b0 || bus.req_RDY !== 4'hF) begin errors++; $display("FAIL all_drained: got ena=%b rdy=%b want 0/1111", bus.heard2__ENA, bus.req_RDY); end
    endtask

    task automatic test_heard2_block();
        do_reset();
        bus.heard__RDY  = 1'b1;
        bus.heard2__RDY = 1'b0;
        bus.req_ENA     = 4'b0110;
        bus.req_type    = 4'b0010;
        bus.req_data[63:32] = pack_heard2(16'h1234, 16'h5678);
        bus.req_data[95:64] = 32'hCAFEF00D;
        tick();
        bus.req_ENA = '0;
        checks++; if (bus.heard__ENA !== 1'b1 || bus.grant_id !== 2'd2 || bus.heard__v !== 32'hCAFEF00D) begin errors++; $display("FAIL blk_req2: got ena=%b gid=%0d v=%h want 1/2/cafef00d", bus.heard__ENA, bus.grant_id, bus.heard__v); end
        checks++; if (bus.req_RDY !== 4'b1001) begin errors++; $display("FAIL blk_rdy: got %b want 1001", bus.req_RDY); end
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++; if (bus.heard__ENA !== 1'b0 || bus.heard2__ENA !== 1'b0) begin errors++; $display("FAIL blk_held[%0d]: got %b%b want 00", k, bus.heard__ENA, bus.heard2__ENA); end
            tick();
        end
        bus.heard2__RDY = 1'b1;
        #1;
        checks++; if (bus.heard2__ENA !== 1'b1 || bus.grant_id !== 2'd1) begin errors++; $display("FAIL blk_release: got ena=%b gid=%0d want 1/1", bus.heard2__ENA, bus.grant_id); end
        checks++; if (bus.heard2__a !== 16'h1234 || bus.heard2__b !== 16'h5678) begin errors++; $display("FAIL blk_ab: got %h,%h want 1234,5678", bus.heard2__a, bus.heard2__b); end
        checks++; if (bus.stall_cnt !== 16'd3) begin errors++; $display("FAIL blk_stall: got %0d want 3", bus.stall_cnt); end
        tick();
        checks++; if (bus.stall_cnt !== 16'd3) begin errors++; $display("FAIL blk_stall_hold: got %0d want 3", bus.stall_cnt); end
    endtask

    task automatic test_stall_saturate();
        do_reset();
        bus.req_ENA  = 4'b0001;
        bus.req_data[31:0] = 32'h0000_5A5A;
        tick();
        bus.req_ENA = '0;
        repeat (65534) tick();
        checks++; if (bus.stall_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_pre: got %h want fffe", bus.stall_cnt); end
        tick();
        checks++; if (bus.stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hit: got %h want ffff", bus.stall_cnt); end
        repeat (3000) tick();
        checks++; if (bus.stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h want ffff", bus.stall_cnt); end
        bus.stall_clr = 1'b1;
        tick();
        bus.stall_clr = 1'b0;
        checks++; if (bus.stall_cnt !== 16'd0) begin errors++; $display("FAIL sat_clr: got %h want 0", bus.stall_cnt); end
        tick();
        checks++; if (bus.stall_cnt !== 16'd1) begin errors++; $display("FAIL sat_restart: got %h want 1", bus.stall_cnt); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        bus.heard__RDY = 1'b1;
        bus.req_ENA    = 4'b0010;
        bus.req_type   = 4'b0000;
        bus.req_data[63:32] = 32'h1;
        tick();
        bus.req_ENA = '0;
        checks++; if (bus.grant_id !== 2'd1 || bus.heard__ENA !== 1'b1) begin errors++; $display("FAIL mid_prep: got gid=%0d ena=%b want 1/1", bus.grant_id, bus.heard__ENA); end
        bus.heard__RDY = 1'b0;
        tick();
        bus.req_ENA = 4'b0111;
        tick();
        bus.req_ENA = '0;
        checks++; if (bus.req_RDY !== 4'b1000) begin errors++; $display("FAIL mid_loaded: got %b want 1000", bus.req_RDY); end
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        bus.heard__RDY  = 1'b1;
        bus.heard2__RDY = 1'b1;
        #1;
        checks++; if (bus.req_RDY !== 4'hF) begin errors++; $display("FAIL mid_rdy: got %b want 1111", bus.req_RDY); end
        checks++; if (bus.heard__ENA !== 1'b0 || bus.heard2__ENA !== 1'b0 || bus.grant_id !== 2'd0) begin errors++; $display("FAIL mid_quiet: got %b%b gid=%0d want 00/0", bus.heard__ENA, bus.heard2__ENA, bus.grant_id); end
        bus.req_ENA = 4'b1010;
        bus.req_data[63:32]  = 32'hAAAA0001;
        bus.req_data[127:96] = 32'hBBBB0003;
        tick();
        bus.req_ENA = '0;
        checks++; if (bus.grant_id !== 2'd1 || bus.heard__v !== 32'hAAAA0001) begin errors++; $display("FAIL mid_ptr0: got gid=%0d v=%h want 1/aaaa0001", bus.grant_id, bus.heard__v); end
        tick();
        checks++; if (bus.grant_id !== 2'd3 || bus.heard__v !== 32'hBBBB0003) begin errors++; $display("FAIL mid_next: got gid=%0d v=%h want 3/bbbb0003", bus.grant_id, bus.heard__v); end
        tick();
        bus.req_ENA = 4'b1000;
        tick();
        bus.req_ENA = '0;
        checks++; if (bus.grant_id !== 2'd3 || bus.heard__ENA !== 1'b1) begin errors++; $display("FAIL mid_req3: got gid=%0d ena=%b want 3/1", bus.grant_id, bus.heard__ENA); end
    endtask

    task automatic test_random();
        int          w;
        logic        e_h, e_h2;
        logic [31:0] e_v, wd;
        logic [IDW-1:0] e_gid;
        logic [NREQ-1:0] e_rdy;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                bus.req_ENA[i]  = !m_valid[i] && ($urandom_range(0, 2) == 0);
                bus.req_type[i] = $urandom_range(0, 1);
                bus.req_data[32*i +: 32] = $urandom;
            end
            bus.heard__RDY  = ($urandom_range(0, 3) != 0);
            bus.heard2__RDY = ($urandom_range(0, 3) != 0);
            bus.stall_clr   = ($urandom_range(0, 49) == 0);
            #3;
            w     = m_win();
            wd    = (w >= 0) ? m_data[w] : '0;
            e_h   = (w >= 0) && !m_kind[w];
            e_h2  = (w >= 0) && m_kind[w];
            e_v   = e_h ? wd : '0;
            e_gid = (w >= 0) ? IDW'(w) : '0;
            for (int i = 0; i < NREQ; i++) e_rdy[i] = !m_valid[i];
            checks++; if ({bus.heard__ENA, bus.heard2__ENA, bus.grant_id} !== {e_h, e_h2, e_gid}) begin errors++; $display("FAIL rnd_issue@%0d: got ena=%b%b gid=%0d want %b%b/%0d", cyc, bus.heard__ENA, bus.heard2__ENA, bus.grant_id, e_h, e_h2, e_gid); end
            checks++; if (bus.heard__v !== e_v || bus.heard2__a !== (e_h2 ? wd[31:16] : 16'd0) || bus.heard2__b !== (e_h2 ? wd[15:0] : 16'd0)) begin errors++; $display("FAIL rnd_payload@%0d: got %h %h %h want from %h", cyc, bus.heard__v, bus.heard2__a, bus.heard2__b, wd); end
            checks++; if (bus.req_RDY !== e_rdy) begin errors++; $display("FAIL rnd_rdy@%0d: got %b want %b", cyc, bus.req_RDY, e_rdy); end
            checks++; if (bus.stall_cnt !== 16'(m_stall)) begin errors++; $display("FAIL rnd_stall@%0d: got %0d want %0d", cyc, bus.stall_cnt, m_stall); end
            tick();
        end
    endtask

    initial begin
        idle_inputs();
        nRST = 1'b0;
        tick();
        tick();
        nRST = 1'b1;
        test_reset();
        test_single_heard();
        test_all_heard2();
        test_heard2_block();
        test_stall_saturate();
        test_reset_midflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
